// File: rtl/writeback.sv
// Writeback stage: 32 x XLEN register file with same-cycle bypass, branch redirect pulse, retirement counter, end-of-program drain FSM.
// Latency: register write and read bypass are visible in the retiring cycle; redirect and count are registered (one cycle later).
// Backpressure: none -- every valid retirement in RUN is accepted; retirements in DRAIN/HALTED are dropped.
module writeback #(
  parameter int XLEN         = 64,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] mem_result_q,
  input  logic [XLEN-1:0] mem_result_q_plus_4,
  input  logic            mem_result_valid_q,
  input  logic            mem_result_is_branch_addr_q,
  input  logic            mem_write_to_rd_q,
  input  logic [4:0]      mem_rd_q,
  input  logic            mem_should_end_program_q,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_addr,
  output logic            halt_req,
  output logic            halted,
  output logic [63:0]     retired_count
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        drain_cnt_q, drain_cnt_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_addr_q, redirect_addr_d;
  logic [63:0]       retired_count_q, retired_count_d;
  logic [XLEN-1:0]   rf_q [32];
  logic [XLEN-1:0]   rf_d [32];

  logic              accept;
  logic              wr_en;
  logic [XLEN-1:0]   wr_dat;

  // Retirement acceptance, write enable and write data selection
  always_comb begin
    accept = mem_result_valid_q && (state_q == ST_RUN);
    wr_en  = accept && mem_write_to_rd_q && (mem_rd_q != 5'd0);
    wr_dat = mem_result_is_branch_addr_q ? mem_result_q_plus_4 : mem_result_q;
  end

  // Combinational read ports; x0 is hardwired, same-cycle write is bypassed
  always_comb begin
    rs1_data = rf_q[rs1_addr];
    rs2_data = rf_q[rs2_addr];
    if (wr_en && (rs1_addr == mem_rd_q)) rs1_data = wr_dat;
    if (wr_en && (rs2_addr == mem_rd_q)) rs2_data = wr_dat;
    if (rs1_addr == 5'd0) rs1_data = '0;
    if (rs2_addr == 5'd0) rs2_data = '0;
  end

  // Register file next state: single write port
  always_comb begin
    rf_d = rf_q;
    if (wr_en) rf_d[mem_rd_q] = wr_dat;
  end

  // FSM next state, drain countdown, redirect pulse and retirement counter
  always_comb begin
    state_d          = state_q;
    drain_cnt_d      = drain_cnt_q;
    redirect_valid_d = 1'b0;
    redirect_addr_d  = redirect_addr_q;
    retired_count_d  = retired_count_q;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          retired_count_d = retired_count_q + 64'd1;
          if (mem_result_is_branch_addr_q) begin
            redirect_valid_d = 1'b1;
            redirect_addr_d  = {mem_result_q[XLEN-1:1], 1'b0};
          end
          if (mem_should_end_program_q) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == 4'd0) state_d = ST_HALTED;
        else                     drain_cnt_d = drain_cnt_q - 4'd1;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Control and counter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_RUN;
      drain_cnt_q      <= 4'd0;
      redirect_valid_q <= 1'b0;
      redirect_addr_q  <= '0;
      retired_count_q  <= 64'd0;
    end else begin
      state_q          <= state_d;
      drain_cnt_q      <= drain_cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_addr_q  <= redirect_addr_d;
      retired_count_q  <= retired_count_d;
    end
  end

  // Register file storage, fully cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_addr  = redirect_addr_q;
  assign retired_count  = retired_count_q;
  assign halt_req       = (state_q == ST_DRAIN);
  assign halted         = (state_q == ST_HALTED);

endmodule

// File: tb/tb_writeback.sv
// Randomized plus directed bench for writeback against a high-level behavioural model.
// Latency: inputs change 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: none in the design; the bench drives a retirement candidate every cycle.
module tb_writeback;

  localparam int XLEN  = 64;
  localparam int DRAIN = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] res, p4;
  logic            vld, br, wr, endp;
  logic [4:0]      rd, a1, a2;
  logic [XLEN-1:0] rs1_data, rs2_data, redirect_addr;
  logic            redirect_valid, halt_req, halted;
  logic [63:0]     retired_count;

  int n_chk = 0;
  int n_err = 0;

  // Model: mode 0=running, 1=draining, 2=halted
  logic [63:0] m_regs [32];
  int          m_mode;
  int          m_left;
  logic [63:0] m_cnt;
  logic        m_rv;
  logic [63:0] m_ra;

  writeback #(.XLEN(XLEN), .DRAIN_CYCLES(DRAIN)) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .mem_result_q                (res),
    .mem_result_q_plus_4         (p4),
    .mem_result_valid_q          (vld),
    .mem_result_is_branch_addr_q (br),
    .mem_write_to_rd_q           (wr),
    .mem_rd_q                    (rd),
    .mem_should_end_program_q    (endp),
    .rs1_addr                    (a1),
    .rs2_addr                    (a2),
    .rs1_data                    (rs1_data),
    .rs2_data                    (rs2_data),
    .redirect_valid              (redirect_valid),
    .redirect_addr               (redirect_addr),
    .halt_req                    (halt_req),
    .halted                      (halted),
    .retired_count               (retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic w, input logic e,
                       input logic [4:0] d, input logic [63:0] r, input logic [63:0] p,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    vld = v; br = b; wr = w; endp = e; rd = d; res = r; p4 = p; a1 = ra1; a2 = ra2;
  endtask

  task automatic idle(input logic [4:0] ra1, input logic [4:0] ra2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, ra1, ra2);
  endtask

  function automatic logic [63:0] m_read(input logic [4:0] a);
    logic        we;
    logic [63:0] wd;
    we = vld && wr && (m_mode == 0) && (rd != 5'd0);
    wd = br ? p4 : res;
    if (a == 5'd0)          return 64'd0;
    if (we && (rd == a))    return wd;
    return m_regs[a];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    m_mode = 0; m_left = 0; m_cnt = 64'd0; m_rv = 1'b0; m_ra = 64'd0;
  endtask

  // One clock: compare all outputs on the falling edge, then advance the model at the rising edge
  task automatic cyc();
    @(negedge clk);
    chk("rs1_data", rs1_data, m_read(a1));
    chk("rs2_data", rs2_data, m_read(a2));
    chk("redirect_valid", {63'd0, redirect_valid}, {63'd0, m_rv});
    if (m_rv) chk("redirect_addr", redirect_addr, m_ra);
    chk("halt_req", {63'd0, halt_req}, {63'd0, m_mode == 1});
    chk("halted", {63'd0, halted}, {63'd0, m_mode == 2});
    chk("retired_count", retired_count, m_cnt);
    @(posedge clk);
    m_rv = 1'b0;
    if (m_mode == 0 && vld) begin
      m_cnt = m_cnt + 64'd1;
      if (wr && rd != 5'd0) m_regs[rd] = br ? p4 : res;
      if (br) begin
        m_rv = 1'b1;
        m_ra = {res[63:1], 1'b0};
      end
      if (endp) begin
        m_mode = 1;
        m_left = DRAIN;
      end
    end else if (m_mode == 1) begin
      m_left--;
      if (m_left == 0) m_mode = 2;
    end
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset(input logic [4:0] ra1, input logic [4:0] ra2);
    idle(ra1, ra2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst halt_req", {63'd0, halt_req}, 64'd0);
    chk("rst halted", {63'd0, halted}, 64'd0);
    chk("rst redirect_valid", {63'd0, redirect_valid}, 64'd0);
    chk("rst redirect_addr", redirect_addr, 64'd0);
    chk("rst retired_count", retired_count, 64'd0);
    chk("rst rs1_data", rs1_data, 64'd0);
    chk("rst rs2_data", rs2_data, 64'd0);
    rst_n = 1'b1;
    m_clear();
  endtask

  initial begin
    logic [4:0] r;
    rst_n = 1'b0;
    idle(5'd0, 5'd0);
    m_clear();
    #12;
    chk("reset halt_req", {63'd0, halt_req}, 64'd0);
    chk("reset halted", {63'd0, halted}, 64'd0);
    chk("reset redirect_valid", {63'd0, redirect_valid}, 64'd0);
    chk("reset retired_count", retired_count, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic write then read back
    drive(1, 0, 1, 0, 5'd5, 64'h1234, 64'h0, 5'd0, 5'd0);
    cyc();
    idle(5'd5, 5'd0);
    #1;
    chk("x5 readback", rs1_data, 64'h1234);
    chk("count after one", retired_count, 64'd1);

    // Same-cycle bypass and x0 discard
    drive(1, 0, 1, 0, 5'd7, 64'hAA, 64'h0, 5'd0, 5'd7);
    #1 chk("bypass rs2", rs2_data, 64'hAA);
    cyc();
    drive(1, 0, 1, 0, 5'd0, 64'hFF, 64'h0, 5'd0, 5'd0);
    #1 chk("x0 same cycle", rs1_data, 64'd0);
    cyc();
    idle(5'd0, 5'd7);
    #1 chk("x0 after write", rs1_data, 64'd0);
    chk("x7 held", rs2_data, 64'hAA);

    // Branch retirement: redirect pulse and link write
    drive(1, 1, 1, 0, 5'd1, 64'h1001, 64'h2000, 5'd0, 5'd0);
    cyc();
    idle(5'd1, 5'd0);
    #1;
    chk("branch redirect_valid", {63'd0, redirect_valid}, 64'd1);
    chk("branch redirect_addr", redirect_addr, 64'h1000);
    chk("branch link x1", rs1_data, 64'h2000);
    cyc();
    chk("redirect one cycle", {63'd0, redirect_valid}, 64'd0);

    // Counter wrap: preload all-ones through the flop input, then retire once
    idle(5'd0, 5'd0);
    force dut.retired_count_d = '1;
    @(posedge clk);
    #1 release dut.retired_count_d;
    m_cnt = '1;
    chk("count preload", retired_count, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1, 0, 0, 0, 5'd0, 64'h0, 64'h0, 5'd0, 5'd0);
    cyc();
    chk("count wrap", retired_count, 64'd0);

    // End of program: fixed drain length, writes ignored while draining
    drive(1, 0, 1, 1, 5'd2, 64'h55, 64'h0, 5'd0, 5'd0);
    cyc();
    for (int i = 0; i < DRAIN; i++) begin
      chk("drain halt_req", {63'd0, halt_req}, 64'd1);
      drive(1, 1, 1, 0, 5'd3, 64'hDEAD, 64'hBEEF, 5'd3, 5'd2);
      cyc();
    end
    chk("halted after drain", {63'd0, halted}, 64'd1);
    chk("halt_req after drain", {63'd0, halt_req}, 64'd0);
    idle(5'd3, 5'd2);
    #1;
    chk("x3 untouched", rs1_data, 64'd0);
    chk("x2 end write", rs2_data, 64'h55);
    chk("count frozen", retired_count, 64'd1);
    cyc();

    // Leave HALTED, then end with a branch and reset mid-drain while redirect is pending
    do_reset(5'd5, 5'd2);
    drive(1, 0, 1, 0, 5'd5, 64'h1234, 64'h0, 5'd0, 5'd0);
    cyc();
    drive(1, 1, 1, 1, 5'd4, 64'h3003, 64'h44, 5'd0, 5'd0);
    cyc();
    chk("end+branch redirect", {63'd0, redirect_valid}, 64'd1);
    chk("end+branch addr", redirect_addr, 64'h3002);
    chk("end+branch drain", {63'd0, halt_req}, 64'd1);
    do_reset(5'd5, 5'd4);
    drive(1, 0, 1, 0, 5'd5, 64'h77, 64'h0, 5'd0, 5'd0);
    cyc();
    idle(5'd5, 5'd0);
    #1 chk("retire after reset", rs1_data, 64'h77);
    chk("count after reset", retired_count, 64'd1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      r = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
            $urandom_range(0, 59) == 0, r, {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 2) == 0) ? r : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? r : 5'($urandom_range(0, 31)));
      cyc();
      if ((m_mode == 2 && $urandom_range(0, 3) == 0) || (m_mode == 1 && $urandom_range(0, 49) == 0))
        do_reset(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
